// File: rtl/wbq_pkg.sv
// -----------------------------------------------------------------------------
// wbq_pkg
// Shared types and constants for the register-file writeback queue.
//   WBQ_DATA_W  : register data width
//   WBQ_ADDR_W  : register index width (16 registers)
//   wbq_entry_t : one queued write, {addr, data}
//   wbq_cnt_w() : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package wbq_pkg;

  localparam int WBQ_DATA_W = 32;
  localparam int WBQ_ADDR_W = 4;

  typedef struct packed {
    logic [WBQ_ADDR_W-1:0] addr;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  // A full queue holds exactly 'depth' entries, so one bit more than the
  // pointer width is needed.
  function automatic int wbq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// -----------------------------------------------------------------------------
// wbq_fwd_match
// Read-port forwarding for the writeback queue. Returns the data of the
// youngest valid entry whose destination equals the read index, otherwise
// the raw register-file value.
//   entries_i : queued entries ordered by age, index 0 = oldest (head)
//   valid_i   : per-age valid mask, same ordering as entries_i
//   sel_i     : register index being read
//   raw_i     : raw register-file read data for sel_i
//   data_o    : forwarded operand
// -----------------------------------------------------------------------------
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbq_entry_t            entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [WBQ_ADDR_W-1:0] sel_i,
  input  logic [WBQ_DATA_W-1:0] raw_i,
  output logic [WBQ_DATA_W-1:0] data_o
);

  // Scan oldest to youngest so a later match overrides an earlier one; the
  // surviving value is the youngest write to that register.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    data_o = raw_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_i[k] && (entries_i[k].addr == sel_i)) begin
        data_o = entries_i[k].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// Circular FIFO of pending register writes sitting in front of the register
// file write port. One entry drains per cycle when the write port is free.
// Both register-file read ports are passed through a forwarding stage so a
// read of a register with a queued write returns the youngest queued value.
//
// Ports
//   Clk       : clock, rising edge
//   Clr       : asynchronous active-low reset; discards all pending writes
//   wr_valid  : producer presents a write
//   wr_ready  : queue can accept a write (not full)
//   wr_addr   : destination register of the presented write
//   wr_data   : data of the presented write
//   drain_en  : register-file write port available this cycle
//   rf_D      : head entry data      -> register file D
//   rf_decin  : head entry address   -> register file decoder
//   rf_LD     : register-file load enable; a pop happens on every edge it is 1
//   rd_sel1/2 : read indices of register-file ports A/B
//   rf_A/B    : raw register-file read data
//   op_A/B    : forwarded operands
//   count     : number of occupied entries
// -----------------------------------------------------------------------------
module writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  logic                        Clk,
  input  logic                        Clr,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        drain_en,
  output logic [DATA_W-1:0]           rf_D,
  output logic [ADDR_W-1:0]           rf_decin,
  output logic                        rf_LD,
  input  logic [ADDR_W-1:0]           rd_sel1,
  input  logic [ADDR_W-1:0]           rd_sel2,
  input  logic [DATA_W-1:0]           rf_A,
  input  logic [DATA_W-1:0]           rf_B,
  output logic [DATA_W-1:0]           op_A,
  output logic [DATA_W-1:0]           op_B,
  output logic [wbq_cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = wbq_cnt_w(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wbq_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  wbq_entry_t         head_entry;

  // ---------------------------------------------------------------------------
  // Handshake and drain control
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on registered occupancy: a pop in this cycle does not
  // open a slot until the following cycle.
  assign wr_ready = !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = !empty && drain_en;

  assign head_entry = entries_q[head_q];
  assign rf_D       = head_entry.data;
  assign rf_decin   = head_entry.addr;
  assign rf_LD      = pop;
  assign count      = count_q;

  // ---------------------------------------------------------------------------
  // Next-state pointers and occupancy
  // ---------------------------------------------------------------------------
  // Pointer arithmetic relies on DEPTH being a power of two so the natural
  // PTR_W-bit overflow is the modulo-DEPTH wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!Clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Clr) begin
    // NOTE: the entry array is deliberately reset; rf_D/rf_decin expose the
    // head entry directly and must read zero out of reset.
    if (!Clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (push) begin
      entries_q[tail_q] <= '{addr: wr_addr, data: wr_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  // Present the entries to the matchers in age order (head first) with a
  // valid bit per age slot, so "youngest match" is simply "last match".
  // Only registered entries take part: the write offered this cycle is not
  // visible to readers until after it is accepted.
  wbq_entry_t       aged_entries [DEPTH];
  logic [DEPTH-1:0] aged_valid;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      aged_entries[k] = entries_q[head_q + PTR_W'(k)];
      aged_valid[k]   = (CNT_W'(k) < count_q);
    end
  end

  wbq_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_a (
    .entries_i (aged_entries),
    .valid_i   (aged_valid),
    .sel_i     (rd_sel1),
    .raw_i     (rf_A),
    .data_o    (op_A)
  );

  wbq_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd_b (
    .entries_i (aged_entries),
    .valid_i   (aged_valid),
    .sel_i     (rd_sel2),
    .raw_i     (rf_B),
    .data_o    (op_B)
  );

endmodule
